// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bits needed to count 0..width-1; never less than one.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bi, with borrow-out bo.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per cycle, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fs_d, fs_bo;
  logic start_ok, last_bit;

  assign start_ok = start && (state_q == IDLE || state_q == DONE);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  full_subtractor u_fs (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .bi (br_q),
    .d  (fs_d),
    .bo (fs_bo)
  );

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so no path through the case leaves state_d
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs: busy and done decode disjoint states, so never overlap.
  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
  end

  // Datapath: a_q doubles as the result shift register, so diff only
  // changes once, on the last bit.
  always_comb begin
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    br_d   = br_q;
    diff_d = diff_q;
    bout_d = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d  = ovf_q;
`endif
    if (start_ok) begin
      cnt_d = '0;
      a_d   = a;
      b_d   = b;
      br_d  = bin;
    end else if (state_q == SHIFT) begin
      cnt_d = cnt_q + CW'(1);
      a_d   = {fs_d, a_q[WIDTH-1:1]};
      b_d   = {1'b0, b_q[WIDTH-1:1]};
      br_d  = fs_bo;
      if (last_bit) begin
        diff_d = {fs_d, a_q[WIDTH-1:1]};
        bout_d = fs_bo;
`ifdef SERIAL_SUB_OVF_EN
        // Signed overflow: borrow into the sign bit differs from borrow out.
        ovf_d  = br_q ^ fs_bo;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: operand and result registers are reset as well as control, so
      // no stale operand or result is visible after reset.
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      br_q   <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      br_q   <= br_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q  <= ovf_d;
`endif
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): vector table plus
// back-to-back, start-during-SHIFT and mid-SHIFT reset sequences.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done, bout;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] ediff;
    logic         ebout;
    logic         eovf;
  } vec_t;

  vec_t vecs[8];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
`ifdef SERIAL_SUB_OVF_EN
    .ovf   (ovf),
`endif
    .bout  (bout)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Raise start at the current negedge; return at the negedge after acceptance.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
    start = 1'b1;
    a     = ia;
    b     = ib;
    bin   = ibin;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge of cycle k+1; returns at the negedge of cycle k+W+1.
  task automatic expect_result(input string tag, input logic [W-1:0] ediff,
                               input logic ebout, input logic eovf);
    for (int i = 0; i < W; i++) begin
      check($sformatf("%s busy[%0d]", tag, i), 32'(busy), 32'd1);
      check($sformatf("%s done_early[%0d]", tag, i), 32'(done), 32'd0);
      @(negedge clk);
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    check({tag, " diff"}, 32'(diff), 32'(ediff));
    check({tag, " bout"}, 32'(bout), 32'(ebout));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, " ovf"}, 32'(ovf), 32'(eovf));
`else
    if (eovf === 1'bx) $display("note: %s has unknown ovf expectation", tag);
`endif
  endtask

  initial begin
    //          a        b        bin   diff     bout  ovf
    vecs[0] = '{4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, 1'b0};
    vecs[1] = '{4'b1010, 4'b0101, 1'b0, 4'b0101, 1'b0, 1'b1};
    vecs[2] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0};
    vecs[3] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0};
    vecs[4] = '{4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1};
    vecs[5] = '{4'b1001, 4'b0011, 1'b1, 4'b0101, 1'b0, 1'b1};
    vecs[6] = '{4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b1, 1'b0};
    vecs[7] = '{4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset diff", 32'(diff), 32'd0);
    check("reset bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table: each result must be held in the idle cycle after done.
    for (int v = 0; v < 8; v++) begin
      issue(vecs[v].a, vecs[v].b, vecs[v].bin);
      expect_result($sformatf("vec%0d", v), vecs[v].ediff, vecs[v].ebout, vecs[v].eovf);
      @(negedge clk);
      check($sformatf("vec%0d done_cleared", v), 32'(done), 32'd0);
      check($sformatf("vec%0d busy_idle", v), 32'(busy), 32'd0);
      check($sformatf("vec%0d diff_held", v), 32'(diff), 32'(vecs[v].ediff));
      check($sformatf("vec%0d bout_held", v), 32'(bout), 32'(vecs[v].ebout));
    end

    // Back-to-back: second start is raised during the done cycle.
    issue(4'b1010, 4'b0101, 1'b0);
    expect_result("b2b_first", 4'b0101, 1'b0, 1'b1);
    issue(4'b0000, 4'b0000, 1'b1);
    expect_result("b2b_second", 4'b1111, 1'b1, 1'b0);
    @(negedge clk);
    check("b2b done_cleared", 32'(done), 32'd0);

    // Start with new operands during SHIFT must be ignored.
    issue(4'b0011, 4'b0101, 1'b0);
    check("ign busy1", 32'(busy), 32'd1);
    start = 1'b1;
    a = 4'b1111;
    b = 4'b0000;
    bin = 1'b0;
    @(negedge clk);
    check("ign busy2", 32'(busy), 32'd1);
    @(negedge clk);
    check("ign busy3", 32'(busy), 32'd1);
    start = 1'b0;
    @(negedge clk);
    check("ign busy4", 32'(busy), 32'd1);
    check("ign done_early", 32'(done), 32'd0);
    @(negedge clk);
    check("ign done", 32'(done), 32'd1);
    check("ign diff", 32'(diff), 32'b1110);
    check("ign bout", 32'(bout), 32'd1);
    @(negedge clk);
    check("ign done_cleared", 32'(done), 32'd0);
    check("ign busy_idle", 32'(busy), 32'd0);

    // Reset for one cycle mid-SHIFT, with start high in the same cycle.
    issue(4'b1010, 4'b0101, 1'b0);
    @(negedge clk);
    check("rst pre busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst diff", 32'(diff), 32'd0);
    check("rst bout", 32'(bout), 32'd0);
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      check($sformatf("rst no_done[%0d]", i), 32'(done), 32'd0);
      check($sformatf("rst no_busy[%0d]", i), 32'(busy), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
